// File: rtl/seq_bit_serializer_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state encoding and sizing helper for the bit serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam logic [1:0] SER_IDLE   = 2'd0;
    localparam logic [1:0] SER_SHIFT  = 2'd1;
    localparam logic [1:0] SER_PARITY = 2'd2;

    // Ceiling log2, used to size the bit counter.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_bit_serializer.sv
// ============================================================================
// Module   : seq_bit_serializer
// Purpose  : MSB-first serializer feeding the sequence detector; back-to-back
//            words with no idle bit. Optional macro SEQ_SER_PARITY_EN appends
//            an even-parity bit after each word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done
);

    localparam int               c_cnt_w    = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
`ifndef SEQ_SER_PARITY_EN
    localparam logic [c_cnt_w-1:0] c_penult_cnt = c_cnt_w'(WIDTH - 2);
`endif

    logic [1:0]         r_state,     w_state_nxt;
    logic [WIDTH-1:0]   r_shift,     w_shift_nxt;
    logic [c_cnt_w-1:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic               r_x_out,     w_x_out_nxt;
    logic               r_x_valid,   w_x_valid_nxt;
    logic               r_word_done, w_word_done_nxt;
    logic               w_xfer;
`ifdef SEQ_SER_PARITY_EN
    logic               r_parity,    w_parity_nxt;
`endif

    // Readiness depends only on state and count, never on din_valid.
`ifdef SEQ_SER_PARITY_EN
    assign din_ready = (r_state == SER_IDLE) || (r_state == SER_PARITY);
`else
    assign din_ready = (r_state == SER_IDLE) ||
                       ((r_state == SER_SHIFT) && (r_bit_cnt == c_last_cnt));
`endif
    assign w_xfer = din_valid && din_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_x_out_nxt     = 1'b0;
        w_x_valid_nxt   = 1'b0;
        w_word_done_nxt = 1'b0;
`ifdef SEQ_SER_PARITY_EN
        w_parity_nxt    = r_parity;
`endif
        if (w_xfer) begin
            w_state_nxt   = SER_SHIFT;
            w_shift_nxt   = din;
            w_bit_cnt_nxt = '0;
            w_x_out_nxt   = din[WIDTH-1];
            w_x_valid_nxt = 1'b1;
`ifdef SEQ_SER_PARITY_EN
            w_parity_nxt  = ^din;
`endif
        end else begin
            case (r_state)
                SER_SHIFT: begin
                    if (r_bit_cnt != c_last_cnt) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_shift_nxt   = r_shift << 1;
                        w_x_out_nxt   = r_shift[WIDTH-2];
                        w_x_valid_nxt = 1'b1;
`ifndef SEQ_SER_PARITY_EN
                        w_word_done_nxt = (r_bit_cnt == c_penult_cnt);
`endif
                    end else begin
`ifdef SEQ_SER_PARITY_EN
                        w_state_nxt     = SER_PARITY;
                        w_x_out_nxt     = r_parity;
                        w_x_valid_nxt   = 1'b1;
                        w_word_done_nxt = 1'b1;
`else
                        w_state_nxt     = SER_IDLE;
`endif
                    end
                end
                SER_PARITY: w_state_nxt = SER_IDLE;
                default:    w_state_nxt = SER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SER_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_x_out     <= 1'b0;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_x_out     <= w_x_out_nxt;
            r_x_valid   <= w_x_valid_nxt;
            r_word_done <= w_word_done_nxt;
`ifdef SEQ_SER_PARITY_EN
            r_parity    <= w_parity_nxt;
`endif
        end
    end

    assign x_out     = r_x_out;
    assign x_valid   = r_x_valid;
    assign word_done = r_word_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
// ============================================================================
// Module   : tb_seq_bit_serializer
// Purpose  : Self-checking bench: vector table, corner sequences, random
//            traffic against a queue-based model. Honours SEQ_SER_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_bit_serializer;

    localparam int WIDTH = 8;
`ifdef SEQ_SER_PARITY_EN
    localparam bit c_par = 1'b1;
`else
    localparam bit c_par = 1'b0;
`endif
    localparam int c_wlen = WIDTH + (c_par ? 1 : 0);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x_out;
    logic             x_valid;
    logic             word_done;

    seq_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x_out     (x_out),
        .x_valid   (x_valid),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    // Model: queue of items still to appear on the wire; front is the current cycle.
    typedef struct {
        logic b;
        logic done;
    } item_t;
    item_t q[$];

    typedef struct {
        bit         rst;
        bit         vld;
        logic [7:0] d;
        bit         rdy;
        bit         xo;
        bit         xv;
        bit         wd;
    } vec_t;
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] d);
        reset     = r;
        din_valid = v;
        din       = d;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic eb, ev, ed, er;
        er = (q.size() <= 1);
        if (q.size() > 0) begin
            eb = q[0].b; ev = 1'b1; ed = q[0].done;
        end else begin
            eb = 1'b0; ev = 1'b0; ed = 1'b0;
        end
        chk({tag, " ready"}, 32'(din_ready), 32'(er));
        chk({tag, " x_out"}, 32'(x_out), 32'(eb));
        chk({tag, " x_valid"}, 32'(x_valid), 32'(ev));
        chk({tag, " word_done"}, 32'(word_done), 32'(ed));
    endtask

    task automatic tick();
        bit         xfer;
        bit         r;
        logic [7:0] d;
        r    = reset;
        d    = din;
        xfer = din_valid && (q.size() <= 1) && !r;
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (xfer) begin
                for (int k = WIDTH - 1; k >= 0; k--)
                    q.push_back('{b: d[k], done: (k == 0) && !c_par});
                if (c_par) q.push_back('{b: ^d, done: 1'b1});
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d, input string tag);
        drive(r, v, d);
        check_model(tag);
        tick();
    endtask

    initial begin
        logic [7:0]  b;
        logic [17:0] stream;
        logic [17:0] exp_stream;
        logic [7:0]  byte_got;
        int          nvalid;
        int          nready;

        drive(1'b1, 1'b1, 8'hFF);
        tick();

        // Reset with valid high, then one word of B4.
        b = 8'hB4;
        tbl.push_back('{1, 1, 8'hFF, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 8'hFF, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 8'hB4, 1, 0, 0, 0});
        for (int k = 7; k >= 0; k--)
            tbl.push_back('{0, 0, 8'h00, (k == 0) && !c_par, b[k], 1, (k == 0) && !c_par});
        if (c_par) tbl.push_back('{0, 0, 8'h00, 1, ^b, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].d);
            chk($sformatf("vec%0d ready", i), 32'(din_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d x_out", i), 32'(x_out), 32'(tbl[i].xo));
            chk($sformatf("vec%0d x_valid", i), 32'(x_valid), 32'(tbl[i].xv));
            chk($sformatf("vec%0d word_done", i), 32'(word_done), 32'(tbl[i].wd));
            check_model($sformatf("vec%0d model", i));
            tick();
        end

        // Back-to-back B0 then BB, valid held until the second word is taken.
        step(1'b0, 1'b1, 8'hB0, "b2b load");
        stream = '0; nvalid = 0; nready = 0;
        for (int i = 0; i < 2 * c_wlen; i++) begin
            drive(1'b0, i <= c_wlen - 1, 8'hBB);
            if (x_valid) begin
                nvalid++;
                stream = {stream[16:0], x_out};
            end
            if (din_ready) nready++;
            check_model("b2b");
            tick();
        end
        exp_stream = c_par ? {8'hB0, 1'b1, 8'hBB, 1'b0} : {2'b00, 8'hB0, 8'hBB};
        chk("b2b stream", 32'(stream), 32'(exp_stream));
        chk("b2b valid count", 32'(nvalid), 32'(2 * c_wlen));
        chk("b2b ready count", 32'(nready), 32'd2);
        step(1'b0, 1'b0, 8'h00, "b2b idle");

        // Reset while the 3rd bit of B4 is on the wire.
        step(1'b0, 1'b1, 8'hB4, "rst load");
        step(1'b0, 1'b0, 8'h00, "rst bit0");
        step(1'b0, 1'b0, 8'h00, "rst bit1");
        drive(1'b1, 1'b0, 8'h00);
        chk("rst bit2 x_out", 32'(x_out), 32'd1);
        check_model("rst bit2");
        tick();
        drive(1'b0, 1'b0, 8'h00);
        chk("after rst x_valid", 32'(x_valid), 32'd0);
        chk("after rst word_done", 32'(word_done), 32'd0);
        check_model("after rst");
        tick();
        step(1'b0, 1'b1, 8'h0B, "0B load");
        byte_got = '0;
        for (int i = 0; i < c_wlen; i++) begin
            drive(1'b0, 1'b0, 8'h00);
            if (i < WIDTH) byte_got = {byte_got[6:0], x_out};
            check_model("0B");
            tick();
        end
        chk("0B word", 32'(byte_got), 32'h0B);

        // Valid toggling with AA while busy on 5C.
        step(1'b0, 1'b1, 8'h5C, "busy load");
        byte_got = '0;
        for (int i = 0; i < c_wlen; i++) begin
            drive(1'b0, (i % 2 == 1) && (i < c_wlen - 1), 8'hAA);
            if (i < WIDTH) byte_got = {byte_got[6:0], x_out};
            check_model("busy");
            tick();
        end
        chk("busy word", 32'(byte_got), 32'h5C);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 8'($urandom), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
